ambi_mem: RTL

AMBI_MEM -- requirements
Module: ambi_mem

---
 rtl/ambi_mem.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ambi_mem.sv
// Instruction/data memory pair for a small accumulator CPU, with a power-up
// clear sequence and a host load port that stalls the CPU while it is active.
module ambi_mem #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int OPCODE_W = 4,
   parameter int DEPTH    = 2 ** ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_W-1:0]             pc,
   output logic [OPCODE_W-1:0]           opcode,
   output logic [ADDR_W-1:0]             operand,
   input  logic                          we,
   input  logic [DATA_W-1:0]             accum,
   output logic [DATA_W-1:0]             ddataout,
   output logic                          cpu_hold,
   input  logic                          ld_req,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic                          ld_sel,
   input  logic [ADDR_W-1:0]             ld_addr,
   input  logic [OPCODE_W+ADDR_W-1:0]    ld_data,
   output logic [7:0]                    ld_cnt
);

   localparam int INST_W = OPCODE_W + ADDR_W;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;

   logic [INST_W-1:0] imem [DEPTH];
   logic [DATA_W-1:0] dmem [DEPTH];

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   logic [ADDR_W-1:0] clr_cnt_reg;
   logic [7:0]        ld_cnt_reg;
   logic              cpu_hold_reg;
   logic              ld_ready_reg;

   logic [INST_W-1:0] inst;
   logic              ld_accept;

   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [INST_W-1:0] imem_wdata;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_waddr;
   logic [DATA_W-1:0] dmem_wdata;

   // CPU-facing reads are asynchronous so a fetch resolves in the same cycle.
   assign inst     = imem[pc];
   assign opcode   = inst[INST_W-1:ADDR_W];
   assign operand  = inst[ADDR_W-1:0];
   assign ddataout = dmem[operand];

   assign cpu_hold  = cpu_hold_reg;
   assign ld_ready  = ld_ready_reg;
   assign ld_cnt    = ld_cnt_reg;
   assign ld_accept = ld_ready_reg & ld_valid;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_CLEAR: if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) state_next = ST_RUN;
         ST_RUN:   if (ld_req) state_next = ST_LOAD;
         ST_LOAD:  if (!ld_req && !ld_valid) state_next = ST_RUN;
         default:  state_next = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_CLEAR;
         clr_cnt_reg  <= '0;
         ld_cnt_reg   <= '0;
         cpu_hold_reg <= 1'b1;
         ld_ready_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cpu_hold_reg <= (state_next != ST_RUN);
         ld_ready_reg <= (state_next == ST_LOAD);
         if (state_reg == ST_CLEAR) clr_cnt_reg <= clr_cnt_reg + 1'b1;
         if (state_reg == ST_RUN && ld_req)
            ld_cnt_reg <= '0;
         else if (ld_accept && ld_cnt_reg != 8'hFF)
            ld_cnt_reg <= ld_cnt_reg + 8'd1;
      end
   end

   // Write-port steering; rst gates every write so nothing lands while held.
   always_comb begin
      imem_we    = 1'b0;
      imem_waddr = clr_cnt_reg;
      imem_wdata = '0;
      dmem_we    = 1'b0;
      dmem_waddr = clr_cnt_reg;
      dmem_wdata = '0;
      if (!rst) begin
         case (state_reg)
            ST_CLEAR: begin
               imem_we = 1'b1;
               dmem_we = 1'b1;
            end
            ST_RUN: begin
               dmem_we    = we;
               dmem_waddr = operand;
               dmem_wdata = accum;
            end
            ST_LOAD: begin
               imem_we    = ld_accept & ld_sel;
               imem_waddr = ld_addr;
               imem_wdata = ld_data;
               dmem_we    = ld_accept & ~ld_sel;
               dmem_waddr = ld_addr;
               dmem_wdata = ld_data[DATA_W-1:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (imem_we) imem[imem_waddr] <= imem_wdata;
      if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
   end

endmodule
